// File: rtl/ir_cursor_ctrl.sv
// Cursor position controller for the IR remote: one step per new direction, then auto-repeat while held.
// Optional CURSOR_WRAP_EN makes out-of-range moves wrap to the opposite edge instead of clamping.
module ir_cursor_ctrl #(
  parameter int H_MAX         = 640,
  parameter int V_MAX         = 480,
  parameter int BOX_SIZE      = 16,
  parameter int STEP          = 4,
  parameter int HOLD_CYCLES   = 12500000,
  parameter int REPEAT_CYCLES = 2500000,
  parameter int X_INIT        = 312,
  parameter int Y_INIT        = 232
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       Up,
  input  logic       Down,
  input  logic       Left,
  input  logic       Right,
  output logic [9:0] CursorX,
  output logic [9:0] CursorY,
  output logic       Moved,
  output logic       EdgeHit,
  output logic       Repeating,
  // 0 = wait-release, 1 = idle, 2 = hold, 3 = repeat
  output logic [1:0] StateDbg
);

  typedef enum logic [1:0] {
    WAIT_RELEASE = 2'd0,
    IDLE         = 2'd1,
    HOLD         = 2'd2,
    REPEAT       = 2'd3
  } state_t;

  localparam logic signed [10:0] X_MAX_S  = 11'(H_MAX - BOX_SIZE);
  localparam logic signed [10:0] Y_MAX_S  = 11'(V_MAX - BOX_SIZE);
  localparam logic signed [10:0] STEP_S   = 11'(STEP);
  localparam logic [23:0]        HOLD_LAST   = 24'(HOLD_CYCLES - 1);
  localparam logic [23:0]        REPEAT_LAST = 24'(REPEAT_CYCLES - 1);

  state_t            state;
  logic [23:0]       counter;
  logic signed [1:0] dx, dy;
  logic signed [1:0] lastDx, lastDy;
  logic              dirActive;
  logic              dirChanged;
  logic              counterDone;
  logic              stepReq;
  logic [10:0]       stepX, stepY;

  // Returns {clipped, new position}; the sum runs in 11-bit signed so negatives are visible.
  function automatic logic [10:0] axisStep(input logic [9:0] pos,
                                           input logic signed [1:0] d,
                                           input logic signed [10:0] maxPos);
    logic signed [10:0] sum;
    logic signed [10:0] wrapped;
    logic               hit;
    logic [9:0]         res;
    sum     = $signed({1'b0, pos});
    wrapped = 11'sd0;
    if (d == 2'sd1) begin
      sum = sum + STEP_S;
    end else if (d == -2'sd1) begin
      sum = sum - STEP_S;
    end
    hit = 1'b0;
    res = sum[9:0];
    if (sum < 11'sd0) begin
      hit = 1'b1;
`ifdef CURSOR_WRAP_EN
      wrapped = sum + maxPos + 11'sd1;
      res     = wrapped[9:0];
`else
      res     = 10'd0;
`endif
    end else if (sum > maxPos) begin
      hit = 1'b1;
`ifdef CURSOR_WRAP_EN
      wrapped = sum - maxPos - 11'sd1;
      res     = wrapped[9:0];
`else
      res     = maxPos[9:0];
`endif
    end
    return {hit, res};
  endfunction

  // Opposing buttons cancel per axis; diagonals pass through.
  always_comb begin
    dx = 2'sd0;
    dy = 2'sd0;
    if (Right && !Left) begin
      dx = 2'sd1;
    end else if (Left && !Right) begin
      dx = -2'sd1;
    end
    if (Down && !Up) begin
      dy = 2'sd1;
    end else if (Up && !Down) begin
      dy = -2'sd1;
    end
  end

  always_comb begin
    dirActive   = (dx != 2'sd0) || (dy != 2'sd0);
    dirChanged  = (dx != lastDx) || (dy != lastDy);
    counterDone = (state == HOLD) ? (counter == HOLD_LAST) : (counter == REPEAT_LAST);
    stepX       = axisStep(CursorX, dx, X_MAX_S);
    stepY       = axisStep(CursorY, dy, Y_MAX_S);
    stepReq     = 1'b0;
    if (state == IDLE) begin
      stepReq = dirActive;
    end else if (state == HOLD || state == REPEAT) begin
      stepReq = dirActive && (dirChanged || counterDone);
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state     <= WAIT_RELEASE;
      counter   <= 24'd0;
      lastDx    <= 2'sd0;
      lastDy    <= 2'sd0;
      CursorX   <= 10'(X_INIT);
      CursorY   <= 10'(Y_INIT);
      Moved     <= 1'b0;
      EdgeHit   <= 1'b0;
      Repeating <= 1'b0;
    end else begin
      Moved   <= 1'b0;
      EdgeHit <= 1'b0;
      if (stepReq) begin
        CursorX <= stepX[9:0];
        CursorY <= stepY[9:0];
        Moved   <= (stepX[9:0] != CursorX) || (stepY[9:0] != CursorY);
        EdgeHit <= stepX[10] || stepY[10];
      end
      case (state)
        WAIT_RELEASE: begin
          if (!dirActive) begin
            state <= IDLE;
          end
        end
        IDLE: begin
          if (dirActive) begin
            lastDx  <= dx;
            lastDy  <= dy;
            counter <= 24'd0;
            state   <= HOLD;
          end
        end
        HOLD, REPEAT: begin
          if (!dirActive) begin
            state     <= IDLE;
            counter   <= 24'd0;
            Repeating <= 1'b0;
          end else if (dirChanged) begin
            // A switch without a release gap restarts the hold delay.
            lastDx    <= dx;
            lastDy    <= dy;
            counter   <= 24'd0;
            state     <= HOLD;
            Repeating <= 1'b0;
          end else if (counterDone) begin
            counter   <= 24'd0;
            state     <= REPEAT;
            Repeating <= 1'b1;
          end else if (counter != 24'hFFFFFF) begin
            counter <= counter + 24'd1;
          end
        end
        default: begin
          state <= WAIT_RELEASE;
        end
      endcase
    end
  end

  assign StateDbg = state;

endmodule

// File: tb/tb_ir_cursor_ctrl.sv
// Self-checking bench for ir_cursor_ctrl with short hold/repeat timing and a step-count reference model.
module tb_ir_cursor_ctrl;

  localparam int H_MAX         = 640;
  localparam int V_MAX         = 480;
  localparam int BOX_SIZE      = 16;
  localparam int STEP          = 4;
  localparam int HOLD_CYCLES   = 10;
  localparam int REPEAT_CYCLES = 4;
  localparam int X_INIT        = 312;
  localparam int Y_INIT        = 232;
  localparam int X_LIM         = H_MAX - BOX_SIZE;
  localparam int Y_LIM         = V_MAX - BOX_SIZE;

  logic       Clock = 1'b0;
  logic       Reset = 1'b0;
  logic       Up = 1'b0, Down = 1'b0, Left = 1'b0, Right = 1'b0;
  logic [9:0] CursorX, CursorY;
  logic       Moved, EdgeHit, Repeating;
  logic [1:0] StateDbg;

  int errors = 0;
  int checks = 0;

  // Reference model: position, pulses, and "cycles since last step" bookkeeping.
  int mX = X_INIT, mY = Y_INIT;
  bit mMoved = 1'b0, mEdge = 1'b0, mRep = 1'b0;
  bit mWait = 1'b1, mHeld = 1'b0;
  int mLastDx = 0, mLastDy = 0, mSince = 0;

  ir_cursor_ctrl #(
    .H_MAX(H_MAX), .V_MAX(V_MAX), .BOX_SIZE(BOX_SIZE), .STEP(STEP),
    .HOLD_CYCLES(HOLD_CYCLES), .REPEAT_CYCLES(REPEAT_CYCLES),
    .X_INIT(X_INIT), .Y_INIT(Y_INIT)
  ) dut (
    .Clock(Clock), .Reset(Reset), .Up(Up), .Down(Down), .Left(Left), .Right(Right),
    .CursorX(CursorX), .CursorY(CursorY), .Moved(Moved), .EdgeHit(EdgeHit),
    .Repeating(Repeating), .StateDbg(StateDbg)
  );

  always #5 Clock = ~Clock;

  function automatic int move_axis(input int p, input int d, input int lim, output bit hit);
    int n;
    n   = p + d * STEP;
    hit = 1'b0;
    if (n < 0) begin
      hit = 1'b1;
`ifdef CURSOR_WRAP_EN
      n = n + lim + 1;
`else
      n = 0;
`endif
    end else if (n > lim) begin
      hit = 1'b1;
`ifdef CURSOR_WRAP_EN
      n = n - (lim + 1);
`else
      n = lim;
`endif
    end
    return n;
  endfunction

  task automatic model_apply(input int dx, input int dy);
    int nx, ny;
    bit hx, hy;
    nx = move_axis(mX, dx, X_LIM, hx);
    ny = move_axis(mY, dy, Y_LIM, hy);
    mMoved = (nx != mX) || (ny != mY);
    mEdge  = hx || hy;
    mX = nx;
    mY = ny;
  endtask

  task automatic model_update();
    int dx, dy;
    dx = (Right && !Left) ? 1 : ((Left && !Right) ? -1 : 0);
    dy = (Down && !Up) ? 1 : ((Up && !Down) ? -1 : 0);
    mMoved = 1'b0;
    mEdge  = 1'b0;
    if (Reset) begin
      mX = X_INIT; mY = Y_INIT; mRep = 1'b0; mWait = 1'b1; mHeld = 1'b0; mSince = 0;
    end else if (mWait) begin
      if (dx == 0 && dy == 0) mWait = 1'b0;
    end else if (dx == 0 && dy == 0) begin
      mHeld = 1'b0;
      mRep  = 1'b0;
    end else if (!mHeld || dx != mLastDx || dy != mLastDy) begin
      model_apply(dx, dy);
      mHeld = 1'b1; mLastDx = dx; mLastDy = dy; mSince = 0; mRep = 1'b0;
    end else begin
      mSince++;
      if (mSince == (mRep ? REPEAT_CYCLES : HOLD_CYCLES)) begin
        model_apply(dx, dy);
        mSince = 0;
        mRep   = 1'b1;
      end
    end
  endtask

  // One clock: model consumes the inputs sampled on this edge; outputs are read 1 ns later.
  task automatic tick();
    @(posedge Clock);
    model_update();
    #1;
  endtask

  task automatic set_dir(input bit u, input bit d, input bit l, input bit r);
    Up = u; Down = d; Left = l; Right = r;
  endtask

  task automatic do_reset();
    set_dir(0, 0, 0, 0);
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    set_dir(0, 0, 0, 0);
    Reset = 1'b1;
    tick();
    tick();
    checks++;
    if ({CursorX, CursorY, Moved, EdgeHit, Repeating} !== {10'd312, 10'd232, 3'b000}) begin
      errors++;
      $display("FAIL reset_values got x=%0d y=%0d mv=%0b eh=%0b rp=%0b want x=312 y=232 mv=0 eh=0 rp=0",
               CursorX, CursorY, Moved, EdgeHit, Repeating);
    end
    Reset = 1'b0;
    tick();
  endtask

  task automatic test_single_pulse();
    set_dir(0, 0, 0, 1);
    tick();
    set_dir(0, 0, 0, 0);
    checks++;
    if ({CursorX, CursorY, Moved, EdgeHit, Repeating} !== {10'd316, 10'd232, 3'b100}) begin
      errors++;
      $display("FAIL pulse_step got x=%0d y=%0d mv=%0b eh=%0b rp=%0b want x=316 y=232 mv=1 eh=0 rp=0",
               CursorX, CursorY, Moved, EdgeHit, Repeating);
    end
    tick();
    checks++;
    if (Moved !== 1'b0 || CursorX !== 10'd316) begin
      errors++;
      $display("FAIL pulse_after got x=%0d mv=%0b want x=316 mv=0", CursorX, Moved);
    end
  endtask

  task automatic test_hold_repeat();
    int steps;
    steps = 0;
    do_reset();
    set_dir(0, 0, 0, 1);
    for (int i = 1; i <= 30; i++) begin
      tick();
      if (Moved === 1'b1) steps++;
      checks++;
      if ({CursorX, CursorY, Moved, EdgeHit, Repeating} !== {10'(mX), 10'(mY), mMoved, mEdge, mRep}) begin
        errors++;
        $display("FAIL hold_cycle %0d got x=%0d y=%0d mv=%0b eh=%0b rp=%0b want x=%0d y=%0d mv=%0b eh=%0b rp=%0b",
                 i, CursorX, CursorY, Moved, EdgeHit, Repeating, mX, mY, mMoved, mEdge, mRep);
      end
      if (i == 11) begin
        checks++;
        if (CursorX !== 10'd320 || Repeating !== 1'b1) begin
          errors++;
          $display("FAIL first_repeat got x=%0d rp=%0b want x=320 rp=1", CursorX, Repeating);
        end
      end
    end
    checks++;
    if (steps != 6) begin
      errors++;
      $display("FAIL hold_step_count got %0d want 6", steps);
    end
    set_dir(0, 0, 0, 0);
    for (int i = 0; i < 10; i++) tick();
    checks++;
    if (CursorX !== 10'd336 || Repeating !== 1'b0 || StateDbg !== 2'd1) begin
      errors++;
      $display("FAIL hold_release got x=%0d rp=%0b st=%0d want x=336 rp=0 st=1", CursorX, Repeating, StateDbg);
    end
  endtask

  task automatic test_diagonal();
    do_reset();
    set_dir(1, 0, 1, 0);
    tick();
    checks++;
    if (CursorX !== 10'd308 || CursorY !== 10'd228 || Moved !== 1'b1) begin
      errors++;
      $display("FAIL diag_up_left got x=%0d y=%0d mv=%0b want x=308 y=228 mv=1", CursorX, CursorY, Moved);
    end
    set_dir(0, 0, 0, 0);
    tick();
    set_dir(1, 1, 0, 1);
    tick();
    checks++;
    if (CursorX !== 10'd312 || CursorY !== 10'd228) begin
      errors++;
      $display("FAIL cancel_ud got x=%0d y=%0d want x=312 y=228", CursorX, CursorY);
    end
    set_dir(0, 0, 0, 0);
    tick();
    set_dir(0, 0, 1, 1);
    for (int i = 0; i < 15; i++) begin
      tick();
      checks++;
      if (CursorX !== 10'd312 || CursorY !== 10'd228 || Moved !== 1'b0 || StateDbg !== 2'd1) begin
        errors++;
        $display("FAIL cancel_lr cycle %0d got x=%0d y=%0d mv=%0b st=%0d want x=312 y=228 mv=0 st=1",
                 i, CursorX, CursorY, Moved, StateDbg);
      end
    end
    set_dir(0, 0, 0, 0);
    tick();
  endtask

  task automatic test_boundary();
    int edges;
    edges = 0;
    do_reset();
    set_dir(0, 0, 0, 1);
    for (int i = 0; i < 340; i++) begin
      tick();
      if (EdgeHit === 1'b1) edges++;
      checks++;
      if ({CursorX, CursorY, Moved, EdgeHit, Repeating} !== {10'(mX), 10'(mY), mMoved, mEdge, mRep}) begin
        errors++;
        $display("FAIL right_wall cycle %0d got x=%0d y=%0d mv=%0b eh=%0b rp=%0b want x=%0d y=%0d mv=%0b eh=%0b rp=%0b",
                 i, CursorX, CursorY, Moved, EdgeHit, Repeating, mX, mY, mMoved, mEdge, mRep);
      end
    end
`ifndef CURSOR_WRAP_EN
    checks++;
    if (CursorX !== 10'd624 || edges != 6) begin
      errors++;
      $display("FAIL right_clamp got x=%0d edges=%0d want x=624 edges=6", CursorX, edges);
    end
`endif
    set_dir(0, 0, 0, 0);
    tick();
    set_dir(1, 0, 1, 0);
    for (int i = 0; i < 700; i++) begin
      tick();
      checks++;
      if ({CursorX, CursorY, Moved, EdgeHit, Repeating} !== {10'(mX), 10'(mY), mMoved, mEdge, mRep}) begin
        errors++;
        $display("FAIL top_left cycle %0d got x=%0d y=%0d mv=%0b eh=%0b rp=%0b want x=%0d y=%0d mv=%0b eh=%0b rp=%0b",
                 i, CursorX, CursorY, Moved, EdgeHit, Repeating, mX, mY, mMoved, mEdge, mRep);
      end
    end
`ifndef CURSOR_WRAP_EN
    checks++;
    if (CursorX !== 10'd0 || CursorY !== 10'd0) begin
      errors++;
      $display("FAIL corner_clamp got x=%0d y=%0d want x=0 y=0", CursorX, CursorY);
    end
`endif
    set_dir(0, 0, 0, 0);
    tick();
  endtask

  task automatic test_switch();
    do_reset();
    set_dir(0, 1, 0, 0);
    for (int i = 0; i < 20; i++) tick();
    checks++;
    if (Repeating !== 1'b1 || CursorY !== 10'd248) begin
      errors++;
      $display("FAIL down_repeat got y=%0d rp=%0b want y=248 rp=1", CursorY, Repeating);
    end
    set_dir(0, 0, 1, 0);
    tick();
    checks++;
    if (CursorX !== 10'd308 || CursorY !== 10'd248 || Moved !== 1'b1 || Repeating !== 1'b0) begin
      errors++;
      $display("FAIL switch_step got x=%0d y=%0d mv=%0b rp=%0b want x=308 y=248 mv=1 rp=0",
               CursorX, CursorY, Moved, Repeating);
    end
    for (int i = 0; i < 12; i++) begin
      tick();
      checks++;
      if ({CursorX, CursorY, Moved, EdgeHit, Repeating} !== {10'(mX), 10'(mY), mMoved, mEdge, mRep}) begin
        errors++;
        $display("FAIL switch_hold cycle %0d got x=%0d y=%0d mv=%0b eh=%0b rp=%0b want x=%0d y=%0d mv=%0b eh=%0b rp=%0b",
                 i, CursorX, CursorY, Moved, EdgeHit, Repeating, mX, mY, mMoved, mEdge, mRep);
      end
    end
    set_dir(0, 0, 0, 0);
    tick();
  endtask

  task automatic test_reset_held();
    set_dir(0, 0, 0, 1);
    tick();
    Reset = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    Reset = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      checks++;
      if (CursorX !== 10'd312 || CursorY !== 10'd232 || Moved !== 1'b0) begin
        errors++;
        $display("FAIL held_thru_reset cycle %0d got x=%0d y=%0d mv=%0b want x=312 y=232 mv=0",
                 i, CursorX, CursorY, Moved);
      end
    end
    set_dir(0, 0, 0, 0);
    tick();
    set_dir(0, 0, 0, 1);
    tick();
    checks++;
    if (CursorX !== 10'd316 || Moved !== 1'b1) begin
      errors++;
      $display("FAIL repress_step got x=%0d mv=%0b want x=316 mv=1", CursorX, Moved);
    end
    set_dir(0, 0, 0, 0);
    tick();
  endtask

  task automatic test_random();
    int len;
    logic [3:0] bits;
    for (int burst = 0; burst < 120; burst++) begin
      bits = 4'($urandom_range(0, 15));
      len  = $urandom_range(1, 24);
      set_dir(bits[3], bits[2], bits[1], bits[0]);
      Reset = ($urandom_range(0, 39) == 0);
      for (int i = 0; i < len; i++) begin
        tick();
        Reset = 1'b0;
        checks++;
        if ({CursorX, CursorY, Moved, EdgeHit, Repeating} !== {10'(mX), 10'(mY), mMoved, mEdge, mRep}) begin
          errors++;
          $display("FAIL random burst %0d cycle %0d got x=%0d y=%0d mv=%0b eh=%0b rp=%0b want x=%0d y=%0d mv=%0b eh=%0b rp=%0b",
                   burst, i, CursorX, CursorY, Moved, EdgeHit, Repeating, mX, mY, mMoved, mEdge, mRep);
        end
      end
    end
    set_dir(0, 0, 0, 0);
    tick();
  endtask

  initial begin
    #2;
    test_reset();
    test_single_pulse();
    test_hold_repeat();
    test_diagonal();
    test_boundary();
    test_switch();
    test_reset_held();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
